bkm_step_controller: RTL and testbench

Sequencer for the BKM iteration datapath (bkm_data_step) in the xfire FPU. Accepts one operation via a valid/ready handshake and pulses the datapath operand load. It then issues exactly N_STEPS step enables with the iteration index and mode, and presents a done/valid handshake once the final step result is registered. One operation in flight at a time. Sits between the FPU issue logic and the BKM datapath.

---
 rtl/bkm_pkg.sv | 18 +
 rtl/bkm_step_controller_if.sv | 21 ++
 rtl/bkm_step_controller.sv | 70 +++++++
 tb/tb_bkm_step_controller.sv | 102 ++++++++++
 4 files changed

// File: rtl/bkm_pkg.sv
// bkm_pkg: shared mode/state encodings and defaults for the BKM step sequencer
package bkm_pkg;
    localparam int BKM_N_STEPS = 32;
    localparam logic BKM_MODE_E = 1'b0;
    localparam logic BKM_MODE_L = 1'b1;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_ITER = ST_ITER,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/bkm_step_controller_if.sv
// bkm_step_controller_if: issue-side handshake plus datapath step controls
interface bkm_step_controller_if #(parameter int CNT_W = 5);
    logic in_valid;
    logic in_mode;
    logic in_ready;
    logic step_load;
    logic step_en;
    logic [CNT_W-1:0] step_n;
    logic step_mode;
    logic busy;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_valid, in_mode, out_ready,
        input in_ready, step_load, step_en, step_n, step_mode, busy, out_valid
    );
    modport slave (
        input in_valid, in_mode, out_ready,
        output in_ready, step_load, step_en, step_n, step_mode, busy, out_valid
    );
endinterface

// File: rtl/bkm_step_controller.sv
// bkm_step_controller: sequences load, N_STEPS iteration enables and result handshake
module bkm_step_controller
    import bkm_pkg::*;
#(
    parameter int N_STEPS = BKM_N_STEPS,
    parameter int CNT_W = $clog2(N_STEPS)
) (
    input logic clk,
    input logic srst,
    input logic enable,
    input logic abort,
    bkm_step_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEPS - 1);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic mode;
    logic out_valid;
    logic busy;
    logic accept;
    assign bus.in_ready = enable & (state == S_IDLE) & ~abort & ~srst;
    assign accept = bus.in_valid & bus.in_ready;
    // step strobes are gated by enable so a frozen cycle never advances the datapath
    assign bus.step_load = enable & (state == S_LOAD);
    assign bus.step_en = enable & (state == S_ITER);
    assign bus.step_n = bus.step_en ? cnt : '0;
    assign bus.step_mode = mode;
    assign bus.busy = busy;
    assign bus.out_valid = out_valid;
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= S_IDLE;
            cnt <= '0;
            mode <= BKM_MODE_E;
            out_valid <= 1'b0;
            busy <= 1'b0;
        end else if (enable) begin
            if (abort) begin
                state <= S_IDLE;
                cnt <= '0;
                out_valid <= 1'b0;
                busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        mode <= bus.in_mode;
                        busy <= 1'b1;
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        cnt <= '0;
                        state <= S_ITER;
                    end
                    S_ITER: if (cnt == LAST) state <= S_WAIT;
                            else cnt <= cnt + 1'b1;
                    S_WAIT: begin
                        out_valid <= 1'b1;
                        state <= S_DONE;
                    end
                    S_DONE: if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        busy <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bkm_step_controller.sv
// tb_bkm_step_controller: directed and random stimulus against a progress-count reference model
module tb_bkm_step_controller;
    localparam int N = 4;
    localparam int W = 2;
    logic clk = 1'b0;
    logic srst, enable, abort;
    int n_checks = 0;
    int n_pass = 0;
    bit active = 1'b0;
    int prog = 0;
    logic mode_m = 1'b0;
    always #5 clk = ~clk;
    bkm_step_controller_if #(.CNT_W(W)) bus();
    bkm_step_controller #(.N_STEPS(N)) dut (
        .clk(clk),
        .srst(srst),
        .enable(enable),
        .abort(abort),
        .bus(bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask
    // model: prog counts enabled cycles since accept (1=load, 2..N+1 steps, N+2 wait, N+3+ done)
    task automatic tick(input bit r, input bit en, input bit ab, input bit iv, input bit im, input bit ordy);
        bit st;
        srst = r;
        enable = en;
        abort = ab;
        bus.in_valid = iv;
        bus.in_mode = im;
        bus.out_ready = ordy;
        @(negedge clk);
        st = en && active && prog >= 2 && prog <= N + 1;
        check("in_ready", 32'(bus.in_ready), 32'(en && !active && !ab && !r));
        check("step_load", 32'(bus.step_load), 32'(en && active && prog == 1));
        check("step_en", 32'(bus.step_en), 32'(st));
        check("step_n", 32'(bus.step_n), st ? 32'(prog - 2) : 32'd0);
        check("step_mode", 32'(bus.step_mode), 32'(mode_m));
        check("busy", 32'(bus.busy), 32'(active));
        check("out_valid", 32'(bus.out_valid), 32'(active && prog >= N + 3));
        @(posedge clk);
        if (r) begin
            active = 1'b0;
            mode_m = 1'b0;
        end else if (en) begin
            if (ab) active = 1'b0;
            else if (!active) begin
                if (iv) begin
                    active = 1'b1;
                    prog = 1;
                    mode_m = im;
                end
            end else if (prog >= N + 3) begin
                if (ordy) active = 1'b0;
            end else prog++;
        end
        #1;
    endtask
    initial begin
        srst = 1'b1;
        enable = 1'b1;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick(1, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 1, 1, 1);
        repeat (8) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 1, 0, 0);
        repeat (11) tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 1);
        tick(0, 1, 0, 1, 1, 1);
        tick(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) tick(0, i % 2 == 0, 0, 0, 0, 1);
        repeat (6) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 1, 0, 1);
        repeat (3) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 1);
        repeat (3) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 1, 1, 1);
        repeat (8) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 1, 1, 1, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 1, 0, 0);
        repeat (8) tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 1, 1, 1);
        repeat (3) tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        repeat (3000) tick($urandom_range(99) == 0, $urandom_range(9) < 8, $urandom_range(29) == 0,
                           1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(9) < 6);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
